// File: rtl/bounce_gen_pkg.sv
// Shared types and LFSR constants for the bounce_gen switch-bounce emulator.
package bounce_gen_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_BOUNCE = 2'd1,
        ST_DONE   = 2'd2
    } state_e;

    localparam int          LfsrWidth       = 16;
    // Galois taps for x^16 + x^14 + x^13 + x^11 + 1, right-shifting form.
    localparam logic [15:0] LfsrPoly        = 16'hB400;
    localparam logic [15:0] LfsrDefaultSeed = 16'hACE1;

    // An all-zero LFSR would lock up, so a zero seed is replaced by 1.
    function automatic logic [LfsrWidth-1:0] lfsr_safe_seed(input logic [LfsrWidth-1:0] seed);
        return (seed == '0) ? LfsrWidth'(1) : seed;
    endfunction

    function automatic logic [LfsrWidth-1:0] lfsr_next(input logic [LfsrWidth-1:0] cur);
        return (cur >> 1) ^ (cur[0] ? LfsrPoly : '0);
    endfunction

endpackage

// File: rtl/bounce_gen_lfsr16.sv
// 16-bit Galois LFSR with enable; advances only when en_i is high.
module lfsr16
    import bounce_gen_pkg::*;
#(
    parameter logic [LfsrWidth-1:0] Seed = LfsrDefaultSeed
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 en_i,
    output logic [LfsrWidth-1:0] lfsr_o
);

    logic [LfsrWidth-1:0] lfsr_q;
    logic [LfsrWidth-1:0] lfsr_d;

    always_comb begin
        lfsr_d = lfsr_q;
        if (en_i) begin
            lfsr_d = lfsr_next(lfsr_q);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            lfsr_q <= lfsr_safe_seed(Seed);
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign lfsr_o = lfsr_q;

endmodule

// File: rtl/bounce_gen.sv
// Mechanical switch emulator: a level-change request makes sw_o chatter for a
// fixed time, then settle. BOUNCE_GEN_RANDOM_EN selects LFSR-driven chatter.
module bounce_gen
    import bounce_gen_pkg::*;
#(
    parameter int unsigned          ClkFreq      = 100_000_000,
    parameter int unsigned          BounceTimeUs = 2000,
    parameter int unsigned          SegLog2      = 4,
    parameter logic [LfsrWidth-1:0] LfsrSeed     = LfsrDefaultSeed
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic req_valid_i,
    input  logic req_level_i,
    output logic req_ready_o,
    output logic sw_o,
    output logic busy_o,
    output logic done_tick_o
);

    localparam longint unsigned BounceCyclesL =
        (64'(ClkFreq) * 64'(BounceTimeUs)) / 64'd1_000_000;
    localparam int unsigned BounceCycles = 32'(BounceCyclesL);
    localparam int          CntW         = $clog2(BounceCycles + 1);
    localparam int          SegW         = SegLog2 + 1;

    if (BounceCycles < 2 || SegLog2 < 1) begin : g_bad_cfg
        $error("bounce_gen: bounce time must span >= 2 cycles and SegLog2 must be >= 1");
    end

    // Handshake: a request transfers on a rising edge where req_valid_i and
    // req_ready_o are both high; ready is high exactly while the FSM is idle,
    // and valid seen in any other state is dropped, not queued.
    state_e          state_q, state_d;
    logic            sw_q, sw_d;
    logic            done_q, done_d;
    logic            target_q, target_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [SegW-1:0] seg_q, seg_d;
    logic [SegW-1:0] seg_reload;
    logic            toggle_en;

`ifdef BOUNCE_GEN_RANDOM_EN
    logic [LfsrWidth-1:0] lfsr;

    lfsr16 #(
        .Seed (LfsrSeed)
    ) u_lfsr (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .en_i   (state_q == ST_BOUNCE),
        .lfsr_o (lfsr)
    );

    assign seg_reload = SegW'(lfsr[SegLog2-1:0]) + SegW'(1);
    assign toggle_en  = lfsr[0];
`else
    assign seg_reload = SegW'(1) << SegLog2;
    assign toggle_en  = 1'b1;
`endif

    always_comb begin
        state_d  = state_q;
        sw_d     = sw_q;
        done_d   = 1'b0;
        target_d = target_q;
        cnt_d    = cnt_q;
        seg_d    = seg_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid_i) begin
                    target_d = req_level_i;
                    if (req_level_i == sw_q) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ST_BOUNCE;
                        cnt_d   = CntW'(BounceCycles);
                        seg_d   = seg_reload;
                    end
                end
            end
            ST_BOUNCE: begin
                // The settle deadline overrides any segment expiring on the same cycle.
                if (cnt_q == CntW'(1)) begin
                    sw_d    = target_q;
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                    cnt_d   = '0;
                    seg_d   = '0;
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                    if (seg_q == SegW'(1)) begin
                        if (toggle_en) begin
                            sw_d = ~sw_q;
                        end
                        seg_d = seg_reload;
                    end else begin
                        seg_d = seg_q - SegW'(1);
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= ST_IDLE;
            sw_q     <= 1'b0;
            done_q   <= 1'b0;
            target_q <= 1'b0;
            cnt_q    <= '0;
            seg_q    <= '0;
        end else begin
            state_q  <= state_d;
            sw_q     <= sw_d;
            done_q   <= done_d;
            target_q <= target_d;
            cnt_q    <= cnt_d;
            seg_q    <= seg_d;
        end
    end

    assign req_ready_o = (state_q == ST_IDLE);
    assign busy_o      = (state_q != ST_IDLE);
    assign sw_o        = sw_q;
    assign done_tick_o = done_q;

endmodule

// File: tb/tb_bounce_gen.sv
// Randomized scoreboard bench for bounce_gen (64-cycle bounce, 4-cycle segments).
`timescale 1ns/1ps
module tb_bounce_gen;

    localparam int unsigned CLK_FREQ   = 1_000_000;
    localparam int unsigned BOUNCE_US  = 64;
    localparam int unsigned SEG_LOG2   = 2;
    localparam int          BOUNCE_CYC = int'((64'(CLK_FREQ) * 64'(BOUNCE_US)) / 64'd1_000_000);
    localparam int          SEG_LEN    = 1 << SEG_LOG2;

    typedef struct {
        logic level;
        int   busy_len;
        int   changes;
        int   off_sum;
    } exp_t;

    logic clk;
    logic rst_i;
    logic req_valid;
    logic req_level;
    logic req_ready_o;
    logic sw_o;
    logic busy_o;
    logic done_tick_o;

    exp_t exp_q[$];
    int   tests_run = 0;
    int   fails     = 0;
    logic model_sw  = 1'b0;

    bounce_gen #(
        .ClkFreq      (CLK_FREQ),
        .BounceTimeUs (BOUNCE_US),
        .SegLog2      (SEG_LOG2),
        .LfsrSeed     (16'hACE1)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .req_valid_i (req_valid),
        .req_level_i (req_level),
        .req_ready_o (req_ready_o),
        .sw_o        (sw_o),
        .busy_o      (busy_o),
        .done_tick_o (done_tick_o)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int expv);
        tests_run++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, expv, $time);
        end
    endtask

    // Reference model: a mismatched request bounces for BOUNCE_CYC cycles,
    // toggling at each whole segment strictly inside that window, then the
    // final edge snaps to target if it is not there already.
    function automatic exp_t model_txn(input logic start, input logic target);
        exp_t e;
        logic lvl;
        e.level   = target;
        e.changes = 0;
        e.off_sum = 0;
        if (start == target) begin
            e.busy_len = 1;
            return e;
        end
        e.busy_len = BOUNCE_CYC + 1;
        lvl = start;
        for (int t = SEG_LEN; t < BOUNCE_CYC; t += SEG_LEN) begin
            lvl = ~lvl;
            e.changes++;
            e.off_sum += t;
        end
        if (lvl != target) begin
            e.changes++;
            e.off_sum += BOUNCE_CYC;
        end
        return e;
    endfunction

    // ---------------- monitor / scoreboard ----------------
    logic in_txn   = 1'b0;
    logic got_done = 1'b0;
    logic prev_sw  = 1'b0;
    int   off      = 0;
    int   blen     = 0;
    int   n_chg    = 0;
    int   off_sum  = 0;

    always @(negedge clk) begin
        if (rst_i) begin
            in_txn   = 1'b0;
            got_done = 1'b0;
        end else if (busy_o) begin
            if (!in_txn) begin
                in_txn   = 1'b1;
                got_done = 1'b0;
                off      = 0;
                blen     = 0;
                n_chg    = 0;
                off_sum  = 0;
            end else begin
                off++;
            end
            blen++;
            if (sw_o != prev_sw) begin
                n_chg++;
                off_sum += off;
            end
            if (done_tick_o) begin
                got_done = 1'b1;
                check("done_has_expected", int'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("final_level", int'(sw_o), int'(e.level));
                    check("busy_len", blen, e.busy_len);
`ifndef BOUNCE_GEN_RANDOM_EN
                    check("sw_changes", n_chg, e.changes);
                    check("change_offset_sum", off_sum, e.off_sum);
`endif
                end
            end
        end else begin
            if (in_txn) begin
                check("done_tick_seen", int'(got_done), 1);
                in_txn = 1'b0;
            end
            check("idle_sw_stable", int'(sw_o), int'(prev_sw));
            check("idle_no_done", int'(done_tick_o), 0);
            check("idle_ready", int'(req_ready_o), 1);
        end
        prev_sw = sw_o;
    end

    // ---------------- driver tasks ----------------
    task automatic do_req(input logic level, input bit noise);
        int guard;
        @(negedge clk);
        req_valid = 1'b1;
        req_level = level;
        exp_q.push_back(model_txn(model_sw, level));
        model_sw = level;
        @(negedge clk);
        guard = 0;
        while (busy_o && guard < 200) begin
            if (noise && !done_tick_o && $urandom_range(0, 3) == 0) begin
                req_valid = 1'b1;
                req_level = 1'($urandom_range(0, 1));
            end else begin
                req_valid = 1'b0;
            end
            @(negedge clk);
            guard++;
        end
        req_valid = 1'b0;
        check("req_completes_in_budget", int'(guard < 200), 1);
    endtask

    task automatic held_test();
        logic lvl;
        int   cyc;
        int   seen;
        int   first_done;
        int   second_done;
        lvl         = ~model_sw;
        cyc         = 0;
        seen        = 0;
        first_done  = -1;
        second_done = -1;
        @(negedge clk);
        req_valid = 1'b1;
        req_level = lvl;
        exp_q.push_back(model_txn(model_sw, lvl));
        exp_q.push_back(model_txn(lvl, lvl));
        model_sw = lvl;
        while (seen < 2 && cyc < 300) begin
            @(negedge clk);
            cyc++;
            if (done_tick_o) begin
                seen++;
                if (seen == 1) first_done = cyc;
                else second_done = cyc;
            end
        end
        req_valid = 1'b0;
        check("held_first_done_cycle", first_done, BOUNCE_CYC + 1);
        check("held_second_done_cycle", second_done, BOUNCE_CYC + 3);
    endtask

    task automatic reset_abort_test();
        do_req(1'b0, 1'b0);
        @(negedge clk);
        req_valid = 1'b1;
        req_level = 1'b1;
        exp_q.push_back(model_txn(model_sw, 1'b1));
        @(negedge clk);
        req_valid = 1'b0;
        repeat (20) @(negedge clk);
        #2;
        rst_i = 1'b1;
        #1;
        check("abort_sw", int'(sw_o), 0);
        check("abort_busy", int'(busy_o), 0);
        check("abort_ready", int'(req_ready_o), 1);
        check("abort_done", int'(done_tick_o), 0);
        exp_q.delete();
        model_sw = 1'b0;
        @(negedge clk);
        #2;
        rst_i = 1'b0;
        repeat (5) begin
            @(negedge clk);
            check("post_abort_no_done", int'(done_tick_o), 0);
            check("post_abort_idle", int'(busy_o), 0);
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        rst_i     = 1'b1;
        req_valid = 1'b0;
        req_level = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_sw", int'(sw_o), 0);
        check("reset_ready", int'(req_ready_o), 1);
        check("reset_busy", int'(busy_o), 0);
        check("reset_done", int'(done_tick_o), 0);
        #2;
        rst_i = 1'b0;
        repeat (2) @(negedge clk);

        do_req(1'b1, 1'b0);
        do_req(1'b1, 1'b0);
        do_req(1'b0, 1'b0);
        do_req(1'b0, 1'b0);
        held_test();
        reset_abort_test();

        for (int i = 0; i < 24; i++) begin
            do_req(1'($urandom_range(0, 1)), 1'b1);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        repeat (4) @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
